iddmm_result_reader: RTL and testbench
======================================

Name: iddmm_result_reader

Overview:
- Consumer end of the Montgomery core's result interface. Collects the N-word "a" stream and the N-word "a - p" stream written by the core, plus the cal_done/cal_sign pair.
- Selects the correct stream from the latched sign, then replays it to downstream logic (exponentiation controller / output packer) LSW-first over a valid/ready handshake.
- Replaces the pair of external FIFOs plus select logic at the core output.

Parameters:
- K, 128, bits per word.
- N, 32, words per operand.
- ADDR_W, $clog2(N), word index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset (asynchronous, active-low)
- fifo_wr_en_a  in  1  write strobe, unreduced-result stream
- fifo_wr_data_a  in  K  unreduced-result word
- fifo_wr_en_sub  in  1  write strobe, subtracted-result stream
- fifo_wr_data_sub  in  K  subtracted-result word (a - p)
- cal_done  in  1  single-cycle end-of-multiplication pulse
- cal_sign  in  1  qualified by cal_done; 1 = use sub stream, 0 = use a stream
- o_valid  out  1  output word valid
- o_data  out  K  output word
- o_addr  out  ADDR_W  word index of o_data, 0 = LSW
- o_last  out  1  high with word N-1
- i_ready  in  1  downstream accepts when o_valid && i_ready
- o_done  out  1  one-cycle pulse after last word accepted
- o_idle  out  1  high in COLLECT with no words or sign captured
- o_overrun  out  1  sticky error flag

Behaviour:
- Reset: all outputs 0 except o_idle = 1. Counters, sign flag and state cleared; buffer contents don't-care. Reset mid-DRAIN aborts and discards the operation.
- Storage: two N x K buffers, buf_a and buf_sub. Write counters cnt_a and cnt_sub, each 0..N, ADDR_W+1 bits.
- State COLLECT:
  - fifo_wr_en_a with cnt_a < N: write buf_a[cnt_a], then cnt_a++.
  - Same rule for the sub stream, independently.
  - Both streams may write in the same cycle.
  - cal_done: latch sel = cal_sign and set sign_vld.
  - A write when the counter is already N, or a cal_done when sign_vld is already set: ignored, and o_overrun set.
- COLLECT -> DRAIN:
  - Taken in the cycle after cnt_a == N, cnt_sub == N and sign_vld all hold, in any arrival order.
  - cal_done arriving in the same cycle as the final write counts.
- State DRAIN:
  - rd_idx starts at 0. o_valid = 1, o_data = sel ? buf_sub[rd_idx] : buf_a[rd_idx], o_addr = rd_idx, o_last = (rd_idx == N-1).
  - o_data, o_addr and o_last are registered and held stable while o_valid && !i_ready.
  - On each accept, rd_idx++. Back-to-back accepts give one word per cycle.
  - First o_valid rises exactly 1 cycle after the transition condition holds. Total minimum latency from completion to last word = N cycles.
- DRAIN -> COLLECT:
  - Taken on acceptance of word N-1.
  - Next cycle: o_valid = 0, o_done = 1 for one cycle; cnt_a, cnt_sub, sign_vld and rd_idx cleared.
- Input activity during DRAIN (any fifo_wr_en_* or cal_done): ignored, and o_overrun set. The upstream controller must wait for o_idle before starting the next multiplication.
- o_overrun clears only on reset.
- o_idle = (state == COLLECT) && cnt_a == 0 && cnt_sub == 0 && !sign_vld.
- No arithmetic is performed. Data passes through unmodified at full K width.

Test Plan:
- Sign 0 select (N=4, K=16): a words 0x1111..0x4444, sub words 0xAAAA..0xDDDD, then cal_done with cal_sign = 0; i_ready = 1 → o_data 0x1111, 0x2222, 0x3333, 0x4444 on consecutive cycles, o_addr 0..3, o_last on the 4th word, o_done pulse one cycle later.
- Sign 1 select: same stimulus with cal_sign = 1 → outputs 0xAAAA..0xDDDD; buf_a content never appears.
- Ordering: cal_done first, sub stream complete before a stream, final a write in the same cycle as nothing else → first o_valid exactly 1 cycle after the 4th a write.
- Backpressure: i_ready toggled 1,0,0,1,1,0,1 → each word held stable while stalled, no word skipped or duplicated; o_done only after word 3 is accepted.
- Overrun: 5 a-stream writes in COLLECT → 5th ignored, o_overrun = 1, output still words 0..3. A write during DRAIN also sets o_overrun and does not alter the output.
- Reset mid-DRAIN after 2 words accepted → o_valid = 0, o_idle = 1 next cycle. A fresh 4-word operation afterwards drains correctly from index 0.

Source files
------------

// File: rtl/iddmm_result_reader.sv
// Collects the a / a-p result streams plus sign, then replays the selected stream LSW-first.
// First word valid 1 cycle after completion, one word/cycle; outputs held while i_ready is low.
`timescale 1ns/1ps
module iddmm_result_reader #(
    parameter int K      = 128,
    parameter int N      = 32,
    parameter int ADDR_W = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_wr_en_a,
    input  logic [K-1:0]      fifo_wr_data_a,
    input  logic              fifo_wr_en_sub,
    input  logic [K-1:0]      fifo_wr_data_sub,
    input  logic              cal_done,
    input  logic              cal_sign,
    output logic              o_valid,
    output logic [K-1:0]      o_data,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last,
    input  logic              i_ready,
    output logic              o_done,
    output logic              o_idle,
    output logic              o_overrun
);
    localparam int CNT_W = ADDR_W + 1;

    typedef enum logic {S_COLLECT = 1'b0, S_DRAIN = 1'b1} state_t;
    state_t state_q, state_d;

    logic [K-1:0]       buf_a_q   [N];
    logic [K-1:0]       buf_sub_q [N];
    logic [CNT_W-1:0]   cnt_a_q, cnt_a_d, cnt_a_nx;
    logic [CNT_W-1:0]   cnt_sub_q, cnt_sub_d, cnt_sub_nx;
    logic               sign_vld_q, sign_vld_d, sign_vld_nx;
    logic               sel_q, sel_d;
    logic [ADDR_W-1:0]  rd_idx_q, rd_idx_d, nxt_idx;
    logic [K-1:0]       data_q, data_d;
    logic               last_q, last_d;
    logic               done_q, done_d;
    logic               ovr_q, ovr_d;
    logic               collect, wr_a_ok, wr_sub_ok, sign_ok;
    logic               complete, accept, accept_last, any_in;

    assign collect     = (state_q == S_COLLECT);
    assign wr_a_ok     = collect && fifo_wr_en_a   && (cnt_a_q   != CNT_W'(N));
    assign wr_sub_ok   = collect && fifo_wr_en_sub && (cnt_sub_q != CNT_W'(N));
    assign sign_ok     = collect && cal_done && !sign_vld_q;
    assign cnt_a_nx    = cnt_a_q   + CNT_W'(wr_a_ok);
    assign cnt_sub_nx  = cnt_sub_q + CNT_W'(wr_sub_ok);
    assign sign_vld_nx = sign_vld_q | sign_ok;
    assign sel_d       = sign_ok ? cal_sign : sel_q;
    assign any_in      = fifo_wr_en_a | fifo_wr_en_sub | cal_done;

    // Completion looks at next-cycle counts so a final write and cal_done in one cycle both count.
    assign complete    = collect && (cnt_a_nx == CNT_W'(N)) && (cnt_sub_nx == CNT_W'(N)) && sign_vld_nx;
    assign accept      = o_valid && i_ready;
    assign accept_last = accept && last_q;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_COLLECT;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_COLLECT: if (complete)    state_d = S_DRAIN;
            S_DRAIN:   if (accept_last) state_d = S_COLLECT;
            default:                    state_d = S_COLLECT;
        endcase
    end

    // Output logic
    always_comb begin
        o_valid = (state_q == S_DRAIN);
        o_idle  = collect && (cnt_a_q == '0) && (cnt_sub_q == '0) && !sign_vld_q;
    end

    assign o_data    = data_q;
    assign o_addr    = rd_idx_q;
    assign o_last    = last_q;
    assign o_done    = done_q;
    assign o_overrun = ovr_q;

    always_comb begin
        cnt_a_d    = accept_last ? '0   : cnt_a_nx;
        cnt_sub_d  = accept_last ? '0   : cnt_sub_nx;
        sign_vld_d = accept_last ? 1'b0 : sign_vld_nx;
        ovr_d      = ovr_q | (collect ? ((fifo_wr_en_a && !wr_a_ok) ||
                                         (fifo_wr_en_sub && !wr_sub_ok) ||
                                         (cal_done && !sign_ok))
                                      : any_in);
        nxt_idx    = complete ? '0 : rd_idx_q + ADDR_W'(1);
        rd_idx_d   = rd_idx_q;
        data_d     = data_q;
        last_d     = last_q;
        done_d     = 1'b0;
        // Output word register is preloaded so o_valid comes up with data already in place.
        if (complete || (accept && !last_q)) begin
            rd_idx_d = nxt_idx;
            data_d   = sel_d ? buf_sub_q[nxt_idx] : buf_a_q[nxt_idx];
            last_d   = (nxt_idx == ADDR_W'(N - 1));
        end else if (accept_last) begin
            rd_idx_d = '0;
            last_d   = 1'b0;
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_a_q    <= '0;
            cnt_sub_q  <= '0;
            sign_vld_q <= 1'b0;
            sel_q      <= 1'b0;
            rd_idx_q   <= '0;
            data_q     <= '0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
        end else begin
            cnt_a_q    <= cnt_a_d;
            cnt_sub_q  <= cnt_sub_d;
            sign_vld_q <= sign_vld_d;
            sel_q      <= sel_d;
            rd_idx_q   <= rd_idx_d;
            data_q     <= data_d;
            last_q     <= last_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_a_ok)   buf_a_q[cnt_a_q[ADDR_W-1:0]]     <= fifo_wr_data_a;
        if (wr_sub_ok) buf_sub_q[cnt_sub_q[ADDR_W-1:0]] <= fifo_wr_data_sub;
    end

endmodule

// File: tb/tb_iddmm_result_reader.sv
// Directed bench for iddmm_result_reader at K=16, N=4.
`timescale 1ns/1ps
module tb_iddmm_result_reader;
    localparam int K = 16;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         fifo_wr_en_a, fifo_wr_en_sub, cal_done, cal_sign, i_ready;
    logic [K-1:0] fifo_wr_data_a, fifo_wr_data_sub;
    logic         o_valid, o_last, o_done, o_idle, o_overrun;
    logic [K-1:0] o_data;
    logic [1:0]   o_addr;

    int total = 0;
    int bad   = 0;

    logic [K-1:0] wa [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [K-1:0] sw [4] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    bit           pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    iddmm_result_reader #(.K(K), .N(N)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .fifo_wr_en_a     (fifo_wr_en_a),
        .fifo_wr_data_a   (fifo_wr_data_a),
        .fifo_wr_en_sub   (fifo_wr_en_sub),
        .fifo_wr_data_sub (fifo_wr_data_sub),
        .cal_done         (cal_done),
        .cal_sign         (cal_sign),
        .o_valid          (o_valid),
        .o_data           (o_data),
        .o_addr           (o_addr),
        .o_last           (o_last),
        .i_ready          (i_ready),
        .o_done           (o_done),
        .o_idle           (o_idle),
        .o_overrun        (o_overrun)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic ea, input logic [K-1:0] da, input logic es,
                        input logic [K-1:0] ds, input logic cd, input logic cs);
        fifo_wr_en_a     = ea;
        fifo_wr_data_a   = da;
        fifo_wr_en_sub   = es;
        fifo_wr_data_sub = ds;
        cal_done         = cd;
        cal_sign         = cs;
        tick();
        fifo_wr_en_a     = 1'b0;
        fifo_wr_en_sub   = 1'b0;
        cal_done         = 1'b0;
        cal_sign         = 1'b0;
        fifo_wr_data_a   = '0;
        fifo_wr_data_sub = '0;
    endtask

    task automatic fill(input logic s);
        for (int i = 0; i < N; i++) step(1'b1, wa[i], 1'b1, sw[i], 1'b0, 1'b0);
        chk("fill_not_valid", o_valid, 0);
        step(1'b0, '0, 1'b0, '0, 1'b1, s);
    endtask

    task automatic drain(input string tag, input logic s);
        i_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_valid%0d", tag, i), o_valid, 1);
            chk($sformatf("%s_data%0d", tag, i), o_data, s ? sw[i] : wa[i]);
            chk($sformatf("%s_addr%0d", tag, i), o_addr, i);
            chk($sformatf("%s_last%0d", tag, i), o_last, (i == N - 1) ? 1 : 0);
            chk($sformatf("%s_nodone%0d", tag, i), o_done, 0);
            tick();
        end
        chk({tag, "_valid_off"}, o_valid, 0);
        chk({tag, "_done"}, o_done, 1);
        chk({tag, "_idle"}, o_idle, 1);
        tick();
        chk({tag, "_done_pulse"}, o_done, 0);
    endtask

    initial begin
        int ptr;
        rst_n = 1'b0;
        i_ready = 1'b0;
        fifo_wr_en_a = 1'b0; fifo_wr_en_sub = 1'b0; cal_done = 1'b0; cal_sign = 1'b0;
        fifo_wr_data_a = '0; fifo_wr_data_sub = '0;
        tick();
        tick();
        chk("rst_valid", o_valid, 0);
        chk("rst_done", o_done, 0);
        chk("rst_last", o_last, 0);
        chk("rst_data", o_data, 0);
        chk("rst_ovr", o_overrun, 0);
        chk("rst_idle", o_idle, 1);
        rst_n = 1'b1;
        tick();

        // Sign 0 selects the a stream
        step(1'b1, 16'h1111, 1'b0, '0, 1'b0, 1'b0);
        chk("t1_not_idle", o_idle, 0);
        for (int i = 1; i < N; i++) step(1'b1, wa[i], 1'b1, sw[i - 1], 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, sw[N - 1], 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        drain("sign0", 1'b0);

        // Sign 1 selects the sub stream
        fill(1'b1);
        drain("sign1", 1'b1);

        // cal_done first, sub complete, a completes last
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        for (int i = 0; i < N; i++) step(1'b0, '0, 1'b1, sw[i], 1'b0, 1'b0);
        for (int i = 0; i < N - 1; i++) step(1'b1, wa[i], 1'b0, '0, 1'b0, 1'b0);
        chk("ord_wait_valid", o_valid, 0);
        chk("ord_wait_idle", o_idle, 0);
        step(1'b1, wa[N - 1], 1'b0, '0, 1'b0, 1'b0);
        chk("ord_valid_1cyc", o_valid, 1);
        drain("order", 1'b0);

        // Backpressure pattern 1,0,0,1,1,0,1
        fill(1'b0);
        ptr = 0;
        for (int c = 0; c < 7; c++) begin
            i_ready = pat[c];
            chk($sformatf("bp_valid%0d", c), o_valid, 1);
            chk($sformatf("bp_data%0d", c), o_data, wa[ptr]);
            chk($sformatf("bp_addr%0d", c), o_addr, ptr);
            chk($sformatf("bp_nodone%0d", c), o_done, 0);
            tick();
            if (pat[c]) ptr++;
        end
        chk("bp_valid_off", o_valid, 0);
        chk("bp_done", o_done, 1);
        tick();
        chk("bp_done_pulse", o_done, 0);

        // Overrun: fifth a write ignored, then activity during drain
        chk("ovr_clear", o_overrun, 0);
        for (int i = 0; i < N; i++) step(1'b1, wa[i], 1'b1, sw[i], 1'b0, 1'b0);
        chk("ovr_before5", o_overrun, 0);
        step(1'b1, 16'h5555, 1'b0, '0, 1'b0, 1'b0);
        chk("ovr_after5", o_overrun, 1);
        chk("ovr_not_valid", o_valid, 0);
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
        i_ready = 1'b0;
        step(1'b1, 16'h9999, 1'b1, 16'h7777, 1'b1, 1'b1);
        chk("ovr_drain_data", o_data, wa[0]);
        drain("ovr", 1'b0);
        chk("ovr_sticky", o_overrun, 1);

        // Reset in the middle of a drain
        fill(1'b0);
        i_ready = 1'b1;
        chk("mid_w0", o_data, wa[0]);
        tick();
        chk("mid_w1", o_data, wa[1]);
        tick();
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", o_valid, 0);
        chk("mid_rst_idle", o_idle, 1);
        chk("mid_rst_ovr", o_overrun, 0);
        rst_n = 1'b1;
        tick();
        fill(1'b1);
        drain("post_rst", 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
